// File: rtl/mem_pkg.sv
// Shared definitions for the parametrised synchronous memory.
//   RD_LAT_MIN/MAX : supported read latencies
//   rd_req_t       : read request carried down the read pipeline
//   be_merge()     : byte-enable merge of a write into an existing word
// Widths are fixed at their maximum here; users zero-extend into and slice out of them.
package mem_pkg;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 2;
    localparam int unsigned ADDR_W_MAX = 32;
    localparam int unsigned DATA_W_MAX = 64;
    localparam int unsigned BE_W_MAX   = DATA_W_MAX / 8;

    typedef struct packed {
        logic [ADDR_W_MAX-1:0] addr;
        logic                  valid;
        logic                  oob;
    } rd_req_t;

    function automatic logic [DATA_W_MAX-1:0] be_merge(
        input logic [DATA_W_MAX-1:0] old_word,
        input logic [DATA_W_MAX-1:0] new_word,
        input logic [BE_W_MAX-1:0]   be
    );
        logic [DATA_W_MAX-1:0] merged;
        for (int i = 0; i < int'(BE_W_MAX); i++) begin
            merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-return pipeline: RD_LAT stages of request + data, flushed by synchronous reset.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset, clears every stage
//   req_i  : read request issued this cycle (valid/oob/addr)
//   data_i : read data resolved at issue time
//   req_o  : request leaving the last stage
//   data_o : data of the last stage; holds its value while no valid request passes
module mem_rd_pipe
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  rd_req_t           req_i,
    input  logic [DATA_W-1:0] data_i,
    output rd_req_t           req_o,
    output logic [DATA_W-1:0] data_o
);

    rd_req_t           req_q  [RD_LAT];
    logic [DATA_W-1:0] data_q [RD_LAT];

    // Data registers only load behind a valid request so the output holds the last read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < int'(RD_LAT); k++) begin
                req_q[k]  <= '0;
                data_q[k] <= '0;
            end
        end else begin
            req_q[0] <= req_i;
            if (req_i.valid) begin
                data_q[0] <= data_i;
            end
            for (int k = 1; k < int'(RD_LAT); k++) begin
                req_q[k] <= req_q[k-1];
                if (req_q[k-1].valid) begin
                    data_q[k] <= data_q[k-1];
                end
            end
        end
    end

    assign req_o  = req_q[RD_LAT-1];
    assign data_o = data_q[RD_LAT-1];

endmodule

// File: rtl/param_sync_mem.sv
// Parametrised single-port synchronous memory with byte enables, 1- or 2-cycle read
// latency, selectable read-during-write policy and out-of-range error strobe.
// Ports:
//   clk_i      : clock, all logic on posedge
//   rst_i      : synchronous active-high reset (clears memory, flushes reads)
//   addr_i     : word address shared by read and write
//   wr_en_i    : write request
//   rd_en_i    : read request
//   wdata_i    : write data
//   be_i       : byte enables, bit i gates wdata_i[8i+7:8i]
//   rdata_o    : read data, meaningful when rd_valid_o=1, otherwise holds
//   rd_valid_o : one-cycle strobe RD_LAT cycles after an accepted read
//   err_o      : one-cycle strobe for an out-of-range access
module param_sync_mem
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 2,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned WR_FIRST = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic                wr_en_i,
    input  logic                rd_en_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                rd_valid_o,
    output logic                err_o
);

    localparam int unsigned BE_W = DATA_W / 8;

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DATA_W-1:0]     mem_d [DEPTH];
    logic [ADDR_W_MAX-1:0] addr_ext;
    logic                  in_range;
    logic                  wr_fire;
    logic [DATA_W-1:0]     cur_word;
    logic [DATA_W-1:0]     merged_word;
    logic [DATA_W-1:0]     rd_data;
    logic [DATA_W_MAX-1:0] cur_ext;
    logic [DATA_W_MAX-1:0] wdata_ext;
    logic [DATA_W_MAX-1:0] merged_ext;
    logic [BE_W_MAX-1:0]   be_ext;
    logic                  wr_err_d;
    logic                  wr_err_q;
    rd_req_t               rd_req;
    rd_req_t               rd_req_out;
    logic [DATA_W-1:0]     pipe_data;
    logic                  unused_merged;
    logic                  unused_req_addr;

    assign addr_ext = {{(ADDR_W_MAX-ADDR_W){1'b0}}, addr_i};
    assign in_range = addr_ext < DEPTH;
    assign wr_fire  = wr_en_i & in_range;
    assign cur_word = in_range ? mem_q[addr_i] : '0;

    always_comb begin
        cur_ext                 = '0;
        cur_ext[DATA_W-1:0]     = cur_word;
        wdata_ext               = '0;
        wdata_ext[DATA_W-1:0]   = wdata_i;
        be_ext                  = '0;
        be_ext[BE_W-1:0]        = be_i;
        merged_ext              = be_merge(cur_ext, wdata_ext, be_ext);
        merged_word             = merged_ext[DATA_W-1:0];
    end

    assign unused_merged = ^merged_ext;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_fire && (addr_ext == i)) begin
                mem_d[i] = merged_word;
            end
        end
    end

    // Read data is resolved at issue so later writes cannot leak into an in-flight read.
    always_comb begin
        rd_data = cur_word;
        if (!in_range) begin
            rd_data = '0;
        end else if ((WR_FIRST != 0) && wr_en_i) begin
            rd_data = merged_word;
        end
    end

    always_comb begin
        rd_req       = '0;
        rd_req.addr  = addr_ext;
        rd_req.valid = rd_en_i;
        rd_req.oob   = rd_en_i & ~in_range;
    end

    // A combined out-of-range write+read reports once, through the read pipeline.
    assign wr_err_d = wr_en_i & ~in_range & ~rd_en_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_err_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_err_q <= wr_err_d;
        end
    end

    mem_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req_i  (rd_req),
        .data_i (rd_data),
        .req_o  (rd_req_out),
        .data_o (pipe_data)
    );

    assign unused_req_addr = ^rd_req_out.addr;

    // Reset outranks a strobe already sitting in the output stage.
    assign rdata_o    = pipe_data;
    assign rd_valid_o = rd_req_out.valid & ~rst_i;
    assign err_o      = (rd_req_out.oob | wr_err_q) & ~rst_i;

endmodule

// File: tb/tb_param_sync_mem.sv
// Bench for param_sync_mem: two configurations driven by shared stimulus.
//   u_dut_a : 8-bit, DEPTH 4, RD_LAT 1, write-first
//   u_dut_b : 16-bit, DEPTH 3, RD_LAT 2, read-first (address 3 is out of range)
module tb_param_sync_mem;

    logic        clk;
    logic        rst;
    logic [1:0]  addr;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] wdata;
    logic [1:0]  be;

    logic [7:0]  a_rdata;
    logic        a_rv;
    logic        a_err;
    logic [15:0] b_rdata;
    logic        b_rv;
    logic        b_err;

    int n_cmp = 0;
    int n_bad = 0;

    param_sync_mem #(
        .DATA_W   (8),
        .ADDR_W   (2),
        .DEPTH    (4),
        .RD_LAT   (1),
        .WR_FIRST (1)
    ) u_dut_a (
        .clk_i      (clk),
        .rst_i      (rst),
        .addr_i     (addr),
        .wr_en_i    (wr_en),
        .rd_en_i    (rd_en),
        .wdata_i    (wdata[7:0]),
        .be_i       (be[0:0]),
        .rdata_o    (a_rdata),
        .rd_valid_o (a_rv),
        .err_o      (a_err)
    );

    param_sync_mem #(
        .DATA_W   (16),
        .ADDR_W   (2),
        .DEPTH    (3),
        .RD_LAT   (2),
        .WR_FIRST (0)
    ) u_dut_b (
        .clk_i      (clk),
        .rst_i      (rst),
        .addr_i     (addr),
        .wr_en_i    (wr_en),
        .rd_en_i    (rd_en),
        .wdata_i    (wdata),
        .be_i       (be),
        .rdata_o    (b_rdata),
        .rd_valid_o (b_rv),
        .err_o      (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Index 0 models u_dut_a, index 1 models u_dut_b. Results are scheduled into a slot
    // ring keyed by the clock edge after which they must be visible.
    localparam int          DEP_M  [2] = '{4, 3};
    localparam int          LAT_M  [2] = '{1, 2};
    localparam int          WF_M   [2] = '{1, 0};
    localparam logic [15:0] MASK_M [2] = '{16'h00ff, 16'hffff};

    logic [15:0] mm   [2][4];
    logic        pv   [2][64];
    logic [15:0] pd   [2][64];
    logic        pe   [2][64];
    logic        cv   [2];
    logic        ce   [2];
    logic [15:0] held [2];
    int          cyc     = 0;
    bit          started = 1'b0;

    function automatic logic [15:0] merge16(input logic [15:0] old_w, input logic [15:0] new_w,
                                            input logic [1:0] b);
        logic [15:0] r;
        r = old_w;
        if (b[0]) r[7:0] = new_w[7:0];
        if (b[1]) r[15:8] = new_w[15:8];
        return r;
    endfunction

    always @(posedge clk) begin
        logic        inr;
        logic [15:0] wd;
        logic [15:0] mg;
        logic [15:0] res;
        int          s;
        cyc++;
        s = cyc % 64;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int j = 0; j < 4; j++) mm[d][j] = 16'h0;
                for (int j = 0; j < 64; j++) begin
                    pv[d][j] = 1'b0;
                    pe[d][j] = 1'b0;
                    pd[d][j] = 16'h0;
                end
                cv[d]   = 1'b0;
                ce[d]   = 1'b0;
                held[d] = 16'h0;
            end else begin
                inr = int'(addr) < DEP_M[d];
                wd  = wdata & MASK_M[d];
                mg  = merge16(mm[d][addr], wd, be) & MASK_M[d];
                if (rd_en) begin
                    if (!inr) res = 16'h0;
                    else if (WF_M[d] != 0 && wr_en) res = mg;
                    else res = mm[d][addr];
                    pv[d][(cyc + LAT_M[d] - 1) % 64] = 1'b1;
                    pd[d][(cyc + LAT_M[d] - 1) % 64] = res;
                    if (!inr) pe[d][(cyc + LAT_M[d] - 1) % 64] = 1'b1;
                end
                if (wr_en) begin
                    if (inr) mm[d][addr] = mg;
                    else if (!rd_en) pe[d][s] = 1'b1;
                end
                cv[d] = pv[d][s];
                ce[d] = pe[d][s];
                if (pv[d][s]) held[d] = pd[d][s];
                pv[d][s] = 1'b0;
                pe[d][s] = 1'b0;
            end
        end
        if (rst) started = 1'b1;
    end

    // Per-cycle comparison; strobes are masked while reset is being applied.
    always @(negedge clk) begin
        if (started) begin
            chk("a_rd_valid", {31'b0, a_rv},  {31'b0, cv[0] & ~rst});
            chk("a_err",      {31'b0, a_err}, {31'b0, ce[0] & ~rst});
            chk("a_rdata",    {24'b0, a_rdata}, {16'b0, held[0]});
            chk("b_rd_valid", {31'b0, b_rv},  {31'b0, cv[1] & ~rst});
            chk("b_err",      {31'b0, b_err}, {31'b0, ce[1] & ~rst});
            chk("b_rdata",    {16'b0, b_rdata}, {16'b0, held[1]});
        end
    end

    // ---------------- stimulus ----------------
    task automatic op(input logic r, input logic w, input logic rdn, input logic [1:0] a,
                      input logic [15:0] wd, input logic [1:0] b);
        rst   = r;
        wr_en = w;
        rd_en = rdn;
        addr  = a;
        wdata = wd;
        be    = b;
        @(posedge clk);
        #2;
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 2'b00);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = 2'd0; wdata = 16'h0; be = 2'b00;
        op(1'b1, 1'b0, 1'b0, 2'd0, 16'h0, 2'b00);
        op(1'b1, 1'b0, 1'b0, 2'd0, 16'h0, 2'b00);
        chk("rst_a_rdata", {24'b0, a_rdata}, 32'h0);
        chk("rst_a_valid", {31'b0, a_rv}, 32'h0);
        chk("rst_b_valid", {31'b0, b_rv}, 32'h0);
        chk("rst_b_err",   {31'b0, b_err}, 32'h0);

        // Fill with ones, reset, read back zeros.
        for (int i = 0; i < 4; i++) op(1'b0, 1'b1, 1'b0, 2'(i), 16'hFFFF, 2'b11);
        chk("t1_b_wr_oob_err", {31'b0, b_err}, 32'h1);
        chk("t1_model_a_ff", {16'b0, mm[0][2]}, 32'h00FF);
        op(1'b1, 1'b0, 1'b0, 2'd0, 16'h0, 2'b00);
        chk("t1_model_a_clr", {16'b0, mm[0][2]}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            op(1'b0, 1'b0, 1'b1, 2'(i), 16'h0, 2'b00);
            chk("t1_a_rdata", {24'b0, a_rdata}, 32'h0);
            chk("t1_a_valid", {31'b0, a_rv}, 32'h1);
        end
        idle();
        chk("t1_b_oob_rdata", {16'b0, b_rdata}, 32'h0);
        chk("t1_b_oob_valid", {31'b0, b_rv}, 32'h1);
        chk("t1_b_oob_err",   {31'b0, b_err}, 32'h1);

        // Write then read, both latencies.
        op(1'b0, 1'b1, 1'b0, 2'd1, 16'h00A5, 2'b11);
        op(1'b0, 1'b0, 1'b1, 2'd1, 16'h0, 2'b00);
        chk("t2_a_rdata", {24'b0, a_rdata}, 32'hA5);
        chk("t2_a_valid", {31'b0, a_rv}, 32'h1);
        idle();
        chk("t2_a_valid_1cyc", {31'b0, a_rv}, 32'h0);
        chk("t2_a_rdata_hold", {24'b0, a_rdata}, 32'hA5);
        chk("t2_b_rdata", {16'b0, b_rdata}, 32'h00A5);
        chk("t2_b_valid", {31'b0, b_rv}, 32'h1);
        idle();
        chk("t2_b_valid_1cyc", {31'b0, b_rv}, 32'h0);

        // Byte enables on the 16-bit instance.
        op(1'b0, 1'b1, 1'b0, 2'd2, 16'h1234, 2'b11);
        op(1'b0, 1'b1, 1'b0, 2'd2, 16'hABCD, 2'b01);
        op(1'b0, 1'b0, 1'b1, 2'd2, 16'h0, 2'b00);
        idle();
        chk("t3_b_be01", {16'b0, b_rdata}, 32'h12CD);
        chk("t3_model_b", {16'b0, mm[1][2]}, 32'h12CD);
        op(1'b0, 1'b1, 1'b0, 2'd2, 16'hFFFF, 2'b00);
        op(1'b0, 1'b0, 1'b1, 2'd2, 16'h0, 2'b00);
        idle();
        chk("t3_b_be00", {16'b0, b_rdata}, 32'h12CD);

        // Read during write at the same address.
        op(1'b0, 1'b1, 1'b0, 2'd1, 16'h0011, 2'b11);
        op(1'b0, 1'b1, 1'b1, 2'd1, 16'h0022, 2'b11);
        chk("t4_a_wr_first", {24'b0, a_rdata}, 32'h22);
        idle();
        chk("t4_b_rd_first", {16'b0, b_rdata}, 32'h0011);
        op(1'b0, 1'b0, 1'b1, 2'd1, 16'h0, 2'b00);
        chk("t4_a_after", {24'b0, a_rdata}, 32'h22);
        idle();
        chk("t4_b_after", {16'b0, b_rdata}, 32'h0022);

        // Out-of-range on the DEPTH=3 instance.
        op(1'b0, 1'b1, 1'b0, 2'd3, 16'h0077, 2'b11);
        chk("t5_b_wr_err", {31'b0, b_err}, 32'h1);
        chk("t5_a_no_err", {31'b0, a_err}, 32'h0);
        idle();
        chk("t5_b_err_1cyc", {31'b0, b_err}, 32'h0);
        op(1'b0, 1'b0, 1'b1, 2'd3, 16'h0, 2'b00);
        chk("t5_a_in_range", {24'b0, a_rdata}, 32'h77);
        idle();
        chk("t5_b_rd_rdata", {16'b0, b_rdata}, 32'h0);
        chk("t5_b_rd_valid", {31'b0, b_rv}, 32'h1);
        chk("t5_b_rd_err",   {31'b0, b_err}, 32'h1);
        op(1'b0, 1'b1, 1'b1, 2'd3, 16'h0055, 2'b11);
        chk("t5_b_both_early", {31'b0, b_err}, 32'h0);
        idle();
        chk("t5_b_both_err", {31'b0, b_err}, 32'h1);
        idle();
        chk("t5_b_both_once", {31'b0, b_err}, 32'h0);

        // Reset drops in-flight reads at RD_LAT=2.
        op(1'b0, 1'b0, 1'b1, 2'd0, 16'h0, 2'b00);
        op(1'b0, 1'b0, 1'b1, 2'd1, 16'h0, 2'b00);
        rst = 1'b1;
        #1;
        chk("t6_b_no_valid0", {31'b0, b_rv}, 32'h0);
        op(1'b1, 1'b0, 1'b0, 2'd0, 16'h0, 2'b00);
        chk("t6_b_no_valid1", {31'b0, b_rv}, 32'h0);
        idle();
        chk("t6_b_no_valid2", {31'b0, b_rv}, 32'h0);
        op(1'b0, 1'b0, 1'b1, 2'd0, 16'h0, 2'b00);
        idle();
        chk("t6_b_rdata", {16'b0, b_rdata}, 32'h0);
        chk("t6_b_valid", {31'b0, b_rv}, 32'h1);

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            op(($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom),
               2'($urandom), 16'($urandom), 2'($urandom));
        end
        repeat (4) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
